l2_request_arbiter: RTL and testbench

- Shares the single L1→L2 request/response channel between the instruction cache (INS) and data cache (DAT) read-miss ports.
- Round-robin arbitration with one outstanding L2 transaction at a time; routes the L2 response back to the requester that owns the transaction.
- Sits between both L1 caches and the L2 cache; the L1 side uses the same valid/ready address and data channels the caches already drive.

---
 rtl/l2_request_arbiter.sv | 134 +++++++++++++
 tb/tb_l2_request_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_request_arbiter.sv
// l2_request_arbiter: shares one L1->L2 read-miss channel between the instruction
// cache (INS) and the data cache (DAT). It uses round-robin grant and allows one
// outstanding L2 transaction at a time. The response goes back to the owning requester.
// Optional build macro: L2_ARBITER_GRANT_COUNTERS_EN adds per-requester grant counters.
module l2_request_arbiter #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned L2_BUS_WIDTH  = 32,
  parameter int unsigned COUNTER_WIDTH = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  // Instruction cache side
  input  logic                     ADDRESS_TO_L2_VALID_INS,
  output logic                     ADDRESS_TO_L2_READY_INS,
  input  logic [ADDRESS_WIDTH-3:0] ADDRESS_TO_L2_INS,
  output logic                     DATA_FROM_L2_VALID_INS,
  input  logic                     DATA_FROM_L2_READY_INS,
  // Data cache side
  input  logic                     ADDRESS_TO_L2_VALID_DAT,
  output logic                     ADDRESS_TO_L2_READY_DAT,
  input  logic [ADDRESS_WIDTH-3:0] ADDRESS_TO_L2_DAT,
  output logic                     DATA_FROM_L2_VALID_DAT,
  input  logic                     DATA_FROM_L2_READY_DAT,
  // Shared response data to both caches
  output logic [L2_BUS_WIDTH-1:0]  DATA_FROM_L2,
  // L2 side
  output logic                     ADDRESS_TO_L2_VALID,
  input  logic                     ADDRESS_TO_L2_READY,
  output logic [ADDRESS_WIDTH-3:0] ADDRESS_TO_L2,
  input  logic                     DATA_FROM_L2_VALID_IN,
  output logic                     DATA_FROM_L2_READY,
  input  logic [L2_BUS_WIDTH-1:0]  DATA_FROM_L2_IN,
  // Status
  output logic                     ARBITER_BUSY,
  output logic                     L2_OWNER
`ifdef L2_ARBITER_GRANT_COUNTERS_EN
  ,
  output logic [COUNTER_WIDTH-1:0] GRANT_COUNT_INS,
  output logic [COUNTER_WIDTH-1:0] GRANT_COUNT_DAT
`endif
);

  typedef enum logic [1:0] {StIdle, StAddr, StResp} state_e;

  state_e                   state_q, state_d;
  logic                     owner_q, owner_d;  // 0 = INS, 1 = DAT
  logic                     prio_q, prio_d;    // requester that wins a tie
  logic [ADDRESS_WIDTH-3:0] addr_q, addr_d;

  logic grant_ins, grant_dat;
  logic resp_ready;

  // Reject configurations that leave no room for a word address or a counter.
  if (ADDRESS_WIDTH < 3 || COUNTER_WIDTH < 1 || L2_BUS_WIDTH < 1) begin : g_bad_cfg
    $error("l2_request_arbiter: illegal parameter values");
  end

  // Tie-break with the priority pointer only when both requesters are valid.
  assign grant_ins = ADDRESS_TO_L2_VALID_INS && (!ADDRESS_TO_L2_VALID_DAT || !prio_q);
  assign grant_dat = ADDRESS_TO_L2_VALID_DAT && (!ADDRESS_TO_L2_VALID_INS || prio_q);

  assign resp_ready = owner_q ? DATA_FROM_L2_READY_DAT : DATA_FROM_L2_READY_INS;

  // Upstream handshake outputs, L2 request outputs and response routing
  assign ADDRESS_TO_L2_READY_INS = (state_q == StIdle) && grant_ins;
  assign ADDRESS_TO_L2_READY_DAT = (state_q == StIdle) && grant_dat;
  assign ADDRESS_TO_L2_VALID     = (state_q == StAddr);
  assign ADDRESS_TO_L2           = addr_q;
  assign DATA_FROM_L2_VALID_INS  = (state_q == StResp) && !owner_q && DATA_FROM_L2_VALID_IN;
  assign DATA_FROM_L2_VALID_DAT  = (state_q == StResp) && owner_q && DATA_FROM_L2_VALID_IN;
  assign DATA_FROM_L2_READY      = (state_q == StResp) && resp_ready;
  assign DATA_FROM_L2            = DATA_FROM_L2_IN;
  assign ARBITER_BUSY            = (state_q != StIdle);
  assign L2_OWNER                = owner_q;

  // Next-state logic: grant in IDLE, hold address until L2 takes it, wait for response
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    addr_d  = addr_q;
    unique case (state_q)
      StIdle: begin
        if (grant_ins || grant_dat) begin
          state_d = StAddr;
          owner_d = grant_dat;
          prio_d  = !grant_dat;
          addr_d  = grant_dat ? ADDRESS_TO_L2_DAT : ADDRESS_TO_L2_INS;
        end
      end
      StAddr: begin
        if (ADDRESS_TO_L2_READY) state_d = StResp;
      end
      StResp: begin
        if (DATA_FROM_L2_VALID_IN && resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset abandons any in-flight transaction
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      addr_q  <= addr_d;
    end
  end

`ifdef L2_ARBITER_GRANT_COUNTERS_EN
  logic [COUNTER_WIDTH-1:0] cnt_ins_q, cnt_dat_q;

  // Count upstream handshakes per requester; wraps naturally at all-ones
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_ins_q <= '0;
      cnt_dat_q <= '0;
    end else begin
      if (ADDRESS_TO_L2_READY_INS) cnt_ins_q <= cnt_ins_q + COUNTER_WIDTH'(1);
      if (ADDRESS_TO_L2_READY_DAT) cnt_dat_q <= cnt_dat_q + COUNTER_WIDTH'(1);
    end
  end

  assign GRANT_COUNT_INS = cnt_ins_q;
  assign GRANT_COUNT_DAT = cnt_dat_q;
`endif

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Directed self-checking bench for l2_request_arbiter.
// Counter checks are active when L2_ARBITER_GRANT_COUNTERS_EN is defined.
module tb_l2_request_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned BW = 32;
  localparam int unsigned CW = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          ADDRESS_TO_L2_VALID_INS, ADDRESS_TO_L2_READY_INS;
  logic [AW-3:0] ADDRESS_TO_L2_INS;
  logic          DATA_FROM_L2_VALID_INS, DATA_FROM_L2_READY_INS;
  logic          ADDRESS_TO_L2_VALID_DAT, ADDRESS_TO_L2_READY_DAT;
  logic [AW-3:0] ADDRESS_TO_L2_DAT;
  logic          DATA_FROM_L2_VALID_DAT, DATA_FROM_L2_READY_DAT;
  logic [BW-1:0] DATA_FROM_L2;
  logic          ADDRESS_TO_L2_VALID, ADDRESS_TO_L2_READY;
  logic [AW-3:0] ADDRESS_TO_L2;
  logic          DATA_FROM_L2_VALID_IN, DATA_FROM_L2_READY;
  logic [BW-1:0] DATA_FROM_L2_IN;
  logic          ARBITER_BUSY, L2_OWNER;
`ifdef L2_ARBITER_GRANT_COUNTERS_EN
  logic [CW-1:0] GRANT_COUNT_INS, GRANT_COUNT_DAT;
`endif

  int checks = 0;
  int errors = 0;

  l2_request_arbiter #(
    .ADDRESS_WIDTH(AW),
    .L2_BUS_WIDTH (BW),
    .COUNTER_WIDTH(CW)
  ) dut (
    .CLK                    (CLK),
    .RST                    (RST),
    .ADDRESS_TO_L2_VALID_INS(ADDRESS_TO_L2_VALID_INS),
    .ADDRESS_TO_L2_READY_INS(ADDRESS_TO_L2_READY_INS),
    .ADDRESS_TO_L2_INS      (ADDRESS_TO_L2_INS),
    .DATA_FROM_L2_VALID_INS (DATA_FROM_L2_VALID_INS),
    .DATA_FROM_L2_READY_INS (DATA_FROM_L2_READY_INS),
    .ADDRESS_TO_L2_VALID_DAT(ADDRESS_TO_L2_VALID_DAT),
    .ADDRESS_TO_L2_READY_DAT(ADDRESS_TO_L2_READY_DAT),
    .ADDRESS_TO_L2_DAT      (ADDRESS_TO_L2_DAT),
    .DATA_FROM_L2_VALID_DAT (DATA_FROM_L2_VALID_DAT),
    .DATA_FROM_L2_READY_DAT (DATA_FROM_L2_READY_DAT),
    .DATA_FROM_L2           (DATA_FROM_L2),
    .ADDRESS_TO_L2_VALID    (ADDRESS_TO_L2_VALID),
    .ADDRESS_TO_L2_READY    (ADDRESS_TO_L2_READY),
    .ADDRESS_TO_L2          (ADDRESS_TO_L2),
    .DATA_FROM_L2_VALID_IN  (DATA_FROM_L2_VALID_IN),
    .DATA_FROM_L2_READY     (DATA_FROM_L2_READY),
    .DATA_FROM_L2_IN        (DATA_FROM_L2_IN),
    .ARBITER_BUSY           (ARBITER_BUSY),
    .L2_OWNER               (L2_OWNER)
`ifdef L2_ARBITER_GRANT_COUNTERS_EN
    ,
    .GRANT_COUNT_INS        (GRANT_COUNT_INS),
    .GRANT_COUNT_DAT        (GRANT_COUNT_DAT)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (observed running, required finished)");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled mid-low-phase.
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic settle();
    #1;
  endtask

  // Checks that every upstream/L2 handshake output is low and the arbiter is idle.
  task automatic chk_quiet(input string tag);
    chk({tag, ".rdy_ins"}, 64'(ADDRESS_TO_L2_READY_INS), 64'd0);
    chk({tag, ".rdy_dat"}, 64'(ADDRESS_TO_L2_READY_DAT), 64'd0);
    chk({tag, ".vld_ins"}, 64'(DATA_FROM_L2_VALID_INS), 64'd0);
    chk({tag, ".vld_dat"}, 64'(DATA_FROM_L2_VALID_DAT), 64'd0);
    chk({tag, ".l2_avld"}, 64'(ADDRESS_TO_L2_VALID), 64'd0);
    chk({tag, ".l2_drdy"}, 64'(DATA_FROM_L2_READY), 64'd0);
    chk({tag, ".busy"}, 64'(ARBITER_BUSY), 64'd0);
  endtask

  task automatic clear_inputs();
    ADDRESS_TO_L2_VALID_INS = 1'b0;
    ADDRESS_TO_L2_INS       = '0;
    DATA_FROM_L2_READY_INS  = 1'b0;
    ADDRESS_TO_L2_VALID_DAT = 1'b0;
    ADDRESS_TO_L2_DAT       = '0;
    DATA_FROM_L2_READY_DAT  = 1'b0;
    ADDRESS_TO_L2_READY     = 1'b0;
    DATA_FROM_L2_VALID_IN   = 1'b0;
    DATA_FROM_L2_IN         = '0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  // One complete INS transaction with an always-ready L2; leaves the arbiter idle.
  task automatic ins_txn(input logic [AW-3:0] a);
    ADDRESS_TO_L2_VALID_INS = 1'b1;
    ADDRESS_TO_L2_INS       = a;
    tick();                                 // handshake taken, now ADDR
    ADDRESS_TO_L2_VALID_INS = 1'b0;
    ADDRESS_TO_L2_READY     = 1'b1;
    tick();                                 // now RESP
    ADDRESS_TO_L2_READY     = 1'b0;
    DATA_FROM_L2_VALID_IN   = 1'b1;
    DATA_FROM_L2_READY_INS  = 1'b1;
    tick();                                 // now IDLE
    DATA_FROM_L2_VALID_IN   = 1'b0;
    DATA_FROM_L2_READY_INS  = 1'b0;
  endtask

  initial begin
    clear_inputs();
    RST = 1'b1;
    @(negedge CLK);
    tick();
    RST = 1'b0;
    settle();
    chk_quiet("reset");
    chk("reset.addr", 64'(ADDRESS_TO_L2), 64'd0);
    chk("reset.owner", 64'(L2_OWNER), 64'd0);

    // Single INS request; L2 accepts on the 2nd ADDR cycle.
    ADDRESS_TO_L2_VALID_INS = 1'b1;
    ADDRESS_TO_L2_INS       = 30'h400;
    settle();
    chk("t1.rdy_ins", 64'(ADDRESS_TO_L2_READY_INS), 64'd1);
    chk("t1.rdy_dat", 64'(ADDRESS_TO_L2_READY_DAT), 64'd0);
    tick();
    ADDRESS_TO_L2_VALID_INS = 1'b0;
    settle();
    chk("t1.rdy_ins_once", 64'(ADDRESS_TO_L2_READY_INS), 64'd0);
    chk("t1.avld_c1", 64'(ADDRESS_TO_L2_VALID), 64'd1);
    chk("t1.addr_c1", 64'(ADDRESS_TO_L2), 64'h400);
    chk("t1.busy", 64'(ARBITER_BUSY), 64'd1);
    tick();
    ADDRESS_TO_L2_READY = 1'b1;
    settle();
    chk("t1.avld_c2", 64'(ADDRESS_TO_L2_VALID), 64'd1);
    chk("t1.addr_c2", 64'(ADDRESS_TO_L2), 64'h400);
    tick();
    ADDRESS_TO_L2_READY    = 1'b0;
    DATA_FROM_L2_VALID_IN  = 1'b1;
    DATA_FROM_L2_IN        = 32'hDEADBEEF;
    DATA_FROM_L2_READY_INS = 1'b1;
    settle();
    chk("t1.avld_resp", 64'(ADDRESS_TO_L2_VALID), 64'd0);
    chk("t1.vld_ins", 64'(DATA_FROM_L2_VALID_INS), 64'd1);
    chk("t1.vld_dat", 64'(DATA_FROM_L2_VALID_DAT), 64'd0);
    chk("t1.data", 64'(DATA_FROM_L2), 64'hDEADBEEF);
    chk("t1.l2_drdy", 64'(DATA_FROM_L2_READY), 64'd1);
    chk("t1.owner", 64'(L2_OWNER), 64'd0);
    tick();
    clear_inputs();
    settle();
    chk("t1.done_busy", 64'(ARBITER_BUSY), 64'd0);
    chk("t1.done_owner", 64'(L2_OWNER), 64'd0);

    // Spurious L2 response valid while idle is not forwarded.
    DATA_FROM_L2_VALID_IN  = 1'b1;
    DATA_FROM_L2_READY_INS = 1'b1;
    DATA_FROM_L2_READY_DAT = 1'b1;
    settle();
    chk_quiet("spur");
    tick();
    clear_inputs();

    // Concurrent requests from reset: INS first, then DAT, then INS again.
    do_reset();
    ADDRESS_TO_L2_VALID_INS = 1'b1;
    ADDRESS_TO_L2_INS       = 30'h10;
    ADDRESS_TO_L2_VALID_DAT = 1'b1;
    ADDRESS_TO_L2_DAT       = 30'h20;
    settle();
    chk("t2.rdy_ins_1", 64'(ADDRESS_TO_L2_READY_INS), 64'd1);
    chk("t2.rdy_dat_1", 64'(ADDRESS_TO_L2_READY_DAT), 64'd0);
    tick();
    ADDRESS_TO_L2_READY = 1'b1;
    settle();
    chk("t2.addr_1", 64'(ADDRESS_TO_L2), 64'h10);
    chk("t2.owner_1", 64'(L2_OWNER), 64'd0);
    chk("t2.no_rdy_busy", 64'({ADDRESS_TO_L2_READY_INS, ADDRESS_TO_L2_READY_DAT}), 64'd0);
    tick();
    DATA_FROM_L2_VALID_IN  = 1'b1;
    DATA_FROM_L2_READY_INS = 1'b1;
    settle();
    chk("t2.vld_ins_1", 64'(DATA_FROM_L2_VALID_INS), 64'd1);
    tick();
    DATA_FROM_L2_VALID_IN  = 1'b0;
    DATA_FROM_L2_READY_INS = 1'b0;
    settle();
    chk("t2.rdy_ins_2", 64'(ADDRESS_TO_L2_READY_INS), 64'd0);
    chk("t2.rdy_dat_2", 64'(ADDRESS_TO_L2_READY_DAT), 64'd1);
    tick();
    settle();
    chk("t2.addr_2", 64'(ADDRESS_TO_L2), 64'h20);
    chk("t2.owner_2", 64'(L2_OWNER), 64'd1);
    tick();
    ADDRESS_TO_L2_READY = 1'b0;

    // DAT owner stalls the response for three cycles.
    DATA_FROM_L2_VALID_IN  = 1'b1;
    DATA_FROM_L2_IN        = 32'h1234_5678;
    DATA_FROM_L2_READY_DAT = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t3.l2_drdy_stall", 64'(DATA_FROM_L2_READY), 64'd0);
      chk("t3.vld_dat_stall", 64'(DATA_FROM_L2_VALID_DAT), 64'd1);
      chk("t3.vld_ins_stall", 64'(DATA_FROM_L2_VALID_INS), 64'd0);
      chk("t3.busy_stall", 64'(ARBITER_BUSY), 64'd1);
      tick();
    end
    DATA_FROM_L2_READY_DAT = 1'b1;
    settle();
    chk("t3.l2_drdy_go", 64'(DATA_FROM_L2_READY), 64'd1);
    tick();
    DATA_FROM_L2_VALID_IN  = 1'b0;
    DATA_FROM_L2_READY_DAT = 1'b0;
    settle();
    chk("t2.rdy_ins_3", 64'(ADDRESS_TO_L2_READY_INS), 64'd1);
    chk("t2.rdy_dat_3", 64'(ADDRESS_TO_L2_READY_DAT), 64'd0);
    tick();

    // Reset while in ADDR.
    clear_inputs();
    settle();
    chk("t4.in_addr", 64'(ADDRESS_TO_L2_VALID), 64'd1);
    do_reset();
    settle();
    chk_quiet("t4.rst_addr");

    // Reset while in RESP, with the pointer left on DAT and L2 valid asserted.
    ins_txn(30'h55);
    ADDRESS_TO_L2_VALID_INS = 1'b1;
    ADDRESS_TO_L2_INS       = 30'h66;
    tick();
    ADDRESS_TO_L2_VALID_INS = 1'b0;
    ADDRESS_TO_L2_READY     = 1'b1;
    tick();
    ADDRESS_TO_L2_READY     = 1'b0;
    DATA_FROM_L2_READY_INS  = 1'b1;
    settle();
    chk("t4.in_resp", 64'(ARBITER_BUSY), 64'd1);
    chk("t4.no_resp_yet", 64'(DATA_FROM_L2_VALID_INS), 64'd0);
    DATA_FROM_L2_VALID_IN = 1'b1;
    RST                   = 1'b1;
    tick();
    RST = 1'b0;
    settle();
    chk_quiet("t4.rst_resp");
    DATA_FROM_L2_VALID_IN   = 1'b0;
    DATA_FROM_L2_READY_INS  = 1'b0;
    ADDRESS_TO_L2_VALID_INS = 1'b1;
    ADDRESS_TO_L2_VALID_DAT = 1'b1;
    settle();
    chk("t4.prio_ins", 64'(ADDRESS_TO_L2_READY_INS), 64'd1);
    chk("t4.prio_dat", 64'(ADDRESS_TO_L2_READY_DAT), 64'd0);
    clear_inputs();

`ifdef L2_ARBITER_GRANT_COUNTERS_EN
    // 17 INS grants on a 4-bit counter wrap to 1.
    do_reset();
    settle();
    chk("cnt.reset_ins", 64'(GRANT_COUNT_INS), 64'd0);
    for (int i = 0; i < 17; i++) ins_txn(30'(i));
    settle();
    chk("cnt.ins_wrap", 64'(GRANT_COUNT_INS), 64'd1);
    chk("cnt.dat_zero", 64'(GRANT_COUNT_DAT), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
